// File: rtl/disparo_escalonador_pkg.sv
// ============================================================================
// disparo_escalonador_pkg : shared defaults, FSM encodings and popcount helper
// Revision 1.0
// ============================================================================
`default_nettype none

package disparo_escalonador_pkg;

    localparam int DEF_N            = 5;
    localparam int DEF_MAX_BALAS    = 2;
    localparam int DEF_COOLDOWN     = 40;
    localparam int DEF_IDLE_TIMEOUT = 200;

    localparam logic [1:0] ESPERA  = 2'd0;
    localparam logic [1:0] DISPARO = 2'd1;
    localparam logic [1:0] RECARGA = 2'd2;

    // Rows are at most 7 wide, so three bits always hold the count.
    function automatic logic [2:0] popcount(input logic [6:0] v);
        logic [2:0] c;
        c = '0;
        for (int i = 0; i < 7; i++) begin
            c = c + {2'b00, v[i]};
        end
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/disparo_escalonador_rr_seletor.sv
// ============================================================================
// rr_seletor : first set request bit at or after ptr, wrapping N-1 -> 0
// Revision 1.0
// ============================================================================
`default_nettype none

module rr_seletor #(
    parameter int N  = 5,
    parameter int PW = 3
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          valid,
    output logic [PW-1:0] idx
);

    // Scan from the farthest offset down so the nearest hit wins.
    always_comb begin
        int j;
        j     = 0;
        valid = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (req[j]) begin
                valid = 1'b1;
                idx   = PW'(j);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/disparo_escalonador.sv
// ============================================================================
// disparo_escalonador : round-robin enemy shot scheduler with bullet cap,
//                       cooldown and idle-timeout forced shot
// Revision 1.0
// ============================================================================
`default_nettype none

module disparo_escalonador
    import disparo_escalonador_pkg::*;
#(
    parameter int N            = DEF_N,
    parameter int MAX_BALAS    = DEF_MAX_BALAS,
    parameter int COOLDOWN     = DEF_COOLDOWN,
    parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
    input  logic         CLOCK_MV,
    input  logic         reset,
    input  logic         reiniciarJogo,
    input  logic         pausa,
    input  logic [N-1:0] vivo,
    input  logic [N-1:0] bola_ativa,
    input  logic [N-1:0] pedido,
    output logic [N-1:0] disparo,
    output logic [2:0]   disparo_idx,
    output logic [2:0]   n_balas,
    output logic         forcado
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(((COOLDOWN > IDLE_TIMEOUT) ? COOLDOWN : IDLE_TIMEOUT) + 1);

    localparam logic [CW-1:0] C_CD_LAST   = CW'(COOLDOWN - 2);
    localparam logic [CW-1:0] C_IDLE_LAST = CW'(IDLE_TIMEOUT - 1);
    localparam logic [CW-1:0] C_ONE       = CW'(1);
    localparam logic [PW-1:0] C_IDX_LAST  = PW'(N - 1);
    localparam logic [2:0]    C_MAX_BALAS = 3'(MAX_BALAS);

    logic [1:0]    r_state;
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] r_pick;
    logic          r_forced;
    logic [CW-1:0] r_cd;
    logic [CW-1:0] r_idle;
    logic [2:0]    r_n_balas;

    logic          w_clear;
    logic [N-1:0]  w_elig;
    logic [N-1:0]  w_req;
    logic          w_has_req;
    logic [2:0]    w_cnt;
    logic          w_cap_ok;
    logic [N-1:0]  w_sel_in;
    logic          w_sel_valid;
    logic [PW-1:0] w_sel_idx;
    logic          w_grant;

    assign w_clear   = reset | reiniciarJogo;
    assign w_elig    = vivo & ~bola_ativa;
    assign w_req     = pedido & w_elig;
    assign w_has_req = |w_req;
    assign w_cnt     = popcount(7'(bola_ativa));
    assign w_cap_ok  = (w_cnt < C_MAX_BALAS);
    // Real requests take precedence; the timeout path picks from all eligible.
    assign w_sel_in  = w_has_req ? w_req : w_elig;

    rr_seletor #(
        .N  (N),
        .PW (PW)
    ) u_rr_seletor (
        .req   (w_sel_in),
        .ptr   (r_ptr),
        .valid (w_sel_valid),
        .idx   (w_sel_idx)
    );

    // The grant is held off while paused or being cleared, and replays on unpause.
    assign w_grant     = (r_state == DISPARO) & ~pausa & ~w_clear;
    assign disparo     = w_grant ? (N'(1) << r_pick) : '0;
    assign forcado     = w_grant & r_forced;
    assign disparo_idx = 3'(r_pick);
    assign n_balas     = r_n_balas;

    always_ff @(posedge CLOCK_MV) begin
        if (w_clear) begin
            r_state   <= ESPERA;
            r_ptr     <= '0;
            r_pick    <= '0;
            r_forced  <= 1'b0;
            r_cd      <= '0;
            r_idle    <= '0;
            r_n_balas <= '0;
        end else if (!pausa) begin
            r_n_balas <= w_cnt;
            case (r_state)
                ESPERA: begin
                    if (w_cap_ok && w_has_req && w_sel_valid) begin
                        r_pick   <= w_sel_idx;
                        r_forced <= 1'b0;
                        r_state  <= DISPARO;
                    end else if (r_idle == C_IDLE_LAST && w_cap_ok && w_sel_valid) begin
                        r_pick   <= w_sel_idx;
                        r_forced <= 1'b1;
                        r_state  <= DISPARO;
                    end else if (r_idle != C_IDLE_LAST) begin
                        r_idle <= r_idle + C_ONE;
                    end
                end
                DISPARO: begin
                    r_ptr   <= (r_pick == C_IDX_LAST) ? '0 : r_pick + PW'(1);
                    r_idle  <= '0;
                    r_cd    <= '0;
                    r_state <= RECARGA;
                end
                RECARGA: begin
                    r_cd <= r_cd + C_ONE;
                    if (r_cd + C_ONE == C_CD_LAST) begin
                        r_state <= ESPERA;
                    end
                end
                default: begin
                    r_state <= ESPERA;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_disparo_escalonador.sv
// ============================================================================
// tb_disparo_escalonador : directed scenarios plus randomized traffic against
//                          a cooldown/idle behavioural model of the scheduler
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_disparo_escalonador;

    localparam int N            = 5;
    localparam int MAX_BALAS    = 2;
    localparam int COOLDOWN     = 40;
    localparam int IDLE_TIMEOUT = 200;

    logic         CLOCK_MV = 1'b0;
    logic         reset = 1'b1;
    logic         reiniciarJogo = 1'b0;
    logic         pausa = 1'b0;
    logic [N-1:0] vivo = '0;
    logic [N-1:0] bola_ativa = '0;
    logic [N-1:0] pedido = '0;
    logic [N-1:0] disparo;
    logic [2:0]   disparo_idx;
    logic [2:0]   n_balas;
    logic         forcado;

    disparo_escalonador #(
        .N            (N),
        .MAX_BALAS    (MAX_BALAS),
        .COOLDOWN     (COOLDOWN),
        .IDLE_TIMEOUT (IDLE_TIMEOUT)
    ) dut (
        .CLOCK_MV      (CLOCK_MV),
        .reset         (reset),
        .reiniciarJogo (reiniciarJogo),
        .pausa         (pausa),
        .vivo          (vivo),
        .bola_ativa    (bola_ativa),
        .pedido        (pedido),
        .disparo       (disparo),
        .disparo_idx   (disparo_idx),
        .n_balas       (n_balas),
        .forcado       (forcado)
    );

    always #5 CLOCK_MV = ~CLOCK_MV;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rel      = 0;
    bit chk_en   = 1'b0;

    // Grant log: enemy index, tick at which the grant is consumed, forced flag.
    int g_idx[$];
    int g_stamp[$];
    int g_forc[$];

    // Behavioural model: a pending shot, remaining cooldown ticks, idle ticks.
    bit m_pend  = 1'b0;
    int m_pidx  = 0;
    bit m_pforc = 1'b0;
    int m_ptr   = 0;
    int m_idle  = 0;
    int m_cool  = 0;
    int m_nb    = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int first_from(input logic [N-1:0] v, input int p);
        for (int o = 0; o < N; o++) begin
            if (v[(p + o) % N]) return (p + o) % N;
        end
        return -1;
    endfunction

    always @(posedge CLOCK_MV) begin
        logic [N-1:0] el;
        logic [N-1:0] rq;
        int cnt;
        cyc++;
        el  = vivo & ~bola_ativa;
        rq  = pedido & el;
        cnt = $countones(bola_ativa);
        if (reset || reiniciarJogo) begin
            m_pend = 1'b0; m_ptr = 0; m_idle = 0; m_cool = 0; m_nb = 0; m_pidx = 0; m_pforc = 1'b0;
        end else if (!pausa) begin
            m_nb = cnt;
            if (m_pend) begin
                m_ptr  = (m_pidx + 1) % N;
                m_idle = 0;
                m_cool = COOLDOWN - 2;
                m_pend = 1'b0;
            end else if (m_cool > 0) begin
                m_cool--;
            end else if (cnt < MAX_BALAS && rq != 0) begin
                m_pidx = first_from(rq, m_ptr); m_pforc = 1'b0; m_pend = 1'b1;
            end else if (m_idle == IDLE_TIMEOUT - 1 && cnt < MAX_BALAS && el != 0) begin
                m_pidx = first_from(el, m_ptr); m_pforc = 1'b1; m_pend = 1'b1;
            end else if (m_idle < IDLE_TIMEOUT - 1) begin
                m_idle++;
            end
        end
    end

    always @(negedge CLOCK_MV) begin
        logic [N-1:0] e_d;
        logic e_f;
        if (chk_en) begin
            e_d = (m_pend && !pausa && !reset && !reiniciarJogo) ? (N'(1) << m_pidx) : '0;
            e_f = (e_d != 0) && m_pforc;
            check("disparo", 32'(disparo), 32'(e_d));
            check("forcado", 32'(forcado), 32'(e_f));
            check("n_balas", 32'(n_balas), 32'(m_nb));
            if (e_d != 0) check("disparo_idx", 32'(disparo_idx), 32'(m_pidx));
        end
        if (disparo != 0) begin
            for (int k = 0; k < N; k++) if (disparo[k]) g_idx.push_back(k);
            g_stamp.push_back(cyc + 1 - rel);
            g_forc.push_back(int'(forcado));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLOCK_MV);
        #1;
    endtask

    task automatic clear_log();
        g_idx.delete(); g_stamp.delete(); g_forc.delete();
    endtask

    task automatic start_test(input logic [N-1:0] v, input logic [N-1:0] b, input logic [N-1:0] p);
        reset = 1'b1; pausa = 1'b0; reiniciarJogo = 1'b0;
        tick(2);
        vivo = v; bola_ativa = b; pedido = p;
        reset = 1'b0;
        rel = cyc;
        clear_log();
    endtask

    task automatic wait_grants(input int n, input int budget, input string nm);
        int k;
        k = 0;
        while (g_idx.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        check(nm, 32'(g_idx.size() >= n), 32'd1);
    endtask

    initial begin
        int exp_t1[6];
        exp_t1 = '{0, 1, 2, 3, 4, 0};

        tick(1);
        chk_en = 1'b1;
        tick(1);
        check("reset_disparo", 32'(disparo), 32'd0);
        check("reset_idx", 32'(disparo_idx), 32'd0);
        check("reset_n_balas", 32'(n_balas), 32'd0);
        check("reset_forcado", 32'(forcado), 32'd0);

        // Rotation across a full row.
        start_test(5'b11111, 5'b00000, 5'b11111);
        wait_grants(6, 400, "t1_timeout");
        bola_ativa = 5'b00011;
        if (g_idx.size() >= 6) begin
            for (int i = 0; i < 6; i++) begin
                check("t1_idx", 32'(g_idx[i]), 32'(exp_t1[i]));
                check("t1_forcado", 32'(g_forc[i]), 32'd0);
                if (i > 0) check("t1_spacing", 32'(g_stamp[i] - g_stamp[i-1]), 32'(COOLDOWN));
            end
        end

        // Cap reached, then one bullet lands; pointer sits at 1 after the rotation.
        clear_log();
        tick(100);
        check("t2_no_grant", 32'(g_idx.size()), 32'd0);
        check("t2_n_balas", 32'(n_balas), 32'd2);
        bola_ativa = 5'b00010;
        wait_grants(1, 100, "t2_timeout");
        if (g_idx.size() >= 1) check("t2_idx", 32'(g_idx[0]), 32'd2);

        // Idle timeout forces shots from the lone survivor.
        start_test(5'b00100, 5'b00000, 5'b00000);
        wait_grants(2, 700, "t3_timeout");
        if (g_idx.size() >= 2) begin
            check("t3_first_tick", 32'(g_stamp[0]), 32'(IDLE_TIMEOUT + 1));
            check("t3_idx", 32'(g_idx[0]), 32'd2);
            check("t3_forcado", 32'(g_forc[0]), 32'd1);
            check("t3_repeat", 32'(g_stamp[1] - g_stamp[0]), 32'(COOLDOWN - 1 + IDLE_TIMEOUT));
            check("t3_forcado2", 32'(g_forc[1]), 32'd1);
        end

        // Pause lands on the grant cycle and defers it.
        start_test(5'b11111, 5'b00000, 5'b00001);
        tick(1);
        pausa = 1'b1;
        @(negedge CLOCK_MV);
        check("t4_paused", 32'(disparo), 32'd0);
        tick(10);
        pausa = 1'b0;
        @(negedge CLOCK_MV);
        check("t4_resume", 32'(disparo), 32'd1);
        wait_grants(2, 100, "t4_timeout");
        if (g_idx.size() >= 2) begin
            check("t4_first_tick", 32'(g_stamp[0]), 32'd12);
            check("t4_spacing", 32'(g_stamp[1] - g_stamp[0]), 32'(COOLDOWN));
        end

        // Reset in the middle of the cooldown.
        start_test(5'b11111, 5'b00000, 5'b00100);
        wait_grants(1, 20, "t5_timeout");
        bola_ativa = 5'b00100;
        pedido = 5'b00000;
        tick(15);
        check("t5_n_balas_pre", 32'(n_balas), 32'd1);
        reset = 1'b1;
        @(negedge CLOCK_MV);
        check("t5_disparo_in_reset", 32'(disparo), 32'd0);
        tick(1);
        reset = 1'b0;
        rel = cyc;
        clear_log();
        @(negedge CLOCK_MV);
        check("t5_n_balas", 32'(n_balas), 32'd0);
        check("t5_idx", 32'(disparo_idx), 32'd0);
        tick(1);
        pedido = 5'b11111;
        wait_grants(1, 20, "t5_grant_timeout");
        if (g_idx.size() >= 1) begin
            check("t5_grant_idx", 32'(g_idx[0]), 32'd0);
            check("t5_grant_tick", 32'(g_stamp[0]), 32'd3);
        end

        // No survivors.
        start_test(5'b00000, 5'b00000, 5'b11111);
        tick(500);
        check("t6_no_grant", 32'(g_idx.size()), 32'd0);

        // Randomized traffic, judged cycle by cycle against the model.
        start_test(5'b11111, 5'b00000, 5'b00000);
        for (int i = 0; i < 4000; i++) begin
            vivo          = N'($urandom | $urandom);
            bola_ativa    = N'($urandom & $urandom & $urandom);
            pedido        = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
            pausa         = ($urandom_range(0, 15) == 0);
            reiniciarJogo = ($urandom_range(0, 299) == 0);
            reset         = ($urandom_range(0, 599) == 0);
            tick(1);
        end
        reset = 1'b0; reiniciarJogo = 1'b0; pausa = 1'b0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
